// File: rtl/imm_instr_encoder_if.sv
// ============================================================
// imm_instr_encoder_if: request handshake and instruction-memory write bus
// Rev 1.0
// ============================================================
`default_nettype none

interface imm_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic        ImmSrc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] Imm;
  logic        Mem_WE;
  logic [31:0] Mem_A;
  logic [31:0] Mem_WD;
  logic        mem_ready;

  modport master (
    output in_valid, ImmSrc, rd, rs1, rs2, Imm, mem_ready,
    input  in_ready, Mem_WE, Mem_A, Mem_WD
  );

  modport slave (
    input  in_valid, ImmSrc, rd, rs1, rs2, Imm, mem_ready,
    output in_ready, Mem_WE, Mem_A, Mem_WD
  );
endinterface

`default_nettype wire

// File: rtl/imm_instr_encoder.sv
// ============================================================
// imm_instr_encoder: range-checks lw/sw offsets, writes encoded words to imem
// Rev 1.0
// ============================================================
`default_nettype none

module imm_instr_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  imm_instr_encoder_if.slave  bus,
  output logic [ADDR_WIDTH:0] instr_count,
  output logic                err,
  output logic [7:0]          rej_count,
  output logic                full
);

  localparam logic [1:0]          c_IDLE       = 2'd0;
  localparam logic [1:0]          c_CHECK      = 2'd1;
  localparam logic [1:0]          c_WRITE      = 2'd2;
  localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [2:0]          c_FUNCT3     = 3'b010;
  localparam logic [6:0]          c_OP_LOAD    = 7'b0000011;
  localparam logic [6:0]          c_OP_STORE   = 7'b0100011;

  logic [1:0]          state_q,   state_d;
  logic                src_q,     src_d;
  logic [4:0]          rd_q,      rd_d;
  logic [4:0]          rs1_q,     rs1_d;
  logic [4:0]          rs2_q,     rs2_d;
  logic [31:0]         imm_q,     imm_d;
  logic [31:0]         mem_a_q,   mem_a_d;
  logic [31:0]         mem_wd_q,  mem_wd_d;
  logic [ADDR_WIDTH:0] cnt_q,     cnt_d;
  logic                err_q,     err_d;
  logic [7:0]          rej_q,     rej_d;

  logic        w_full;
  logic        w_in_ready;
  logic        w_in_range;
  logic [31:0] w_lw_word;
  logic [31:0] w_sw_word;

  assign w_full     = (cnt_q == c_FULL_COUNT);
  assign w_in_ready = (state_q == c_IDLE) && !w_full;
  // Fits signed 12-bit when bits 31..11 are a pure sign extension
  assign w_in_range = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign w_lw_word  = {imm_q[11:0], rs1_q, c_FUNCT3, rd_q, c_OP_LOAD};
  assign w_sw_word  = {imm_q[11:5], rs2_q, rs1_q, c_FUNCT3, imm_q[4:0], c_OP_STORE};

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    rej_d    = rej_q;
    case (state_q)
      c_IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          src_d   = bus.ImmSrc;
          rd_d    = bus.rd;
          rs1_d   = bus.rs1;
          rs2_d   = bus.rs2;
          imm_d   = bus.Imm;
          state_d = c_CHECK;
        end
      end
      c_CHECK: begin
        if (w_in_range) begin
          mem_wd_d = src_q ? w_sw_word : w_lw_word;
          state_d  = c_WRITE;
        end else begin
          err_d   = 1'b1;
          if (rej_q != 8'hFF) rej_d = rej_q + 8'd1;
          state_d = c_IDLE;
        end
      end
      c_WRITE: begin
        if (bus.mem_ready) begin
          mem_a_d = mem_a_q + 32'd4;
          cnt_d   = cnt_q + 1'b1;
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // clear behaves exactly like reset, including dropping a pending write
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      state_q  <= c_IDLE;
      src_q    <= 1'b0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      mem_a_q  <= BASE_ADDR;
      mem_wd_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rej_q    <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rej_q    <= rej_d;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.Mem_WE   = (state_q == c_WRITE);
  assign bus.Mem_A    = mem_a_q;
  assign bus.Mem_WD   = mem_wd_q;
  assign instr_count  = cnt_q;
  assign err          = err_q;
  assign rej_count    = rej_q;
  assign full         = w_full;

endmodule

`default_nettype wire
